// File: rtl/mux_n_stream_pkg.sv
// rtl/mux_n_stream_pkg.sv - shared constants and helpers for the N:1 stream multiplexer
package mux_n_stream_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// rtl/rr_arbiter_n.sv - round-robin grant over CH requests, pointer advances on accepted grant
module rr_arbiter_n #(
    parameter int CH   = 4,
    parameter int SELW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH-1:0]   req,
    input  logic            advance,
    output logic [SELW-1:0] grant_idx,
    output logic            grant_valid
);

    logic [SELW-1:0] ptr;

    // Search starts just past the last winner so every requester is reached within CH grants.
    always_comb begin
        int idx;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 1; k <= CH; k++) begin
            idx = (int'(ptr) + k) % CH;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx[SELW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= SELW'(CH - 1);
        end else if (advance) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/mux_n_stream.sv
// rtl/mux_n_stream.sv - registered N:1 stream multiplexer, select-driven or round-robin
module mux_n_stream
    import mux_n_stream_pkg::*;
#(
    parameter  int n    = 32,
    parameter  int CH   = 4,
    parameter  int RR   = MODE_SEL,
    localparam int SELW = clog2(CH)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [CH*n-1:0] IN_DATA,
    input  logic [CH-1:0]   IN_VALID,
    output logic [CH-1:0]   IN_READY,
    input  logic [SELW-1:0] SEL,
    output logic [n-1:0]    OUT,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [SELW-1:0] OUT_CH
);

    logic            load_en;
    logic            grant_valid;
    logic            in_xfer;
    logic [SELW-1:0] grant_idx;
    logic [CH-1:0]   ready_vec;

    assign load_en = !OUT_VALID || OUT_READY;

    generate
        if (RR == MODE_RR) begin : g_rr
            logic unused_sel;
            assign unused_sel = ^SEL;

            rr_arbiter_n #(
                .CH   (CH),
                .SELW (SELW)
            ) u_arb (
                .clk         (CLK),
                .rst         (RST),
                .req         (IN_VALID),
                .advance     (in_xfer),
                .grant_idx   (grant_idx),
                .grant_valid (grant_valid)
            );
        end else begin : g_sel
            // Out-of-range selects (non-power-of-2 CH) simply grant nobody.
            localparam logic [SELW:0] CH_LIMIT = (SELW + 1)'(CH);
            assign grant_idx   = SEL;
            assign grant_valid = ({1'b0, SEL} < CH_LIMIT);
        end
    endgenerate

    always_comb begin
        ready_vec = '0;
        if (grant_valid && load_en && !RST) begin
            ready_vec[grant_idx] = 1'b1;
        end
    end

    assign IN_READY = ready_vec;
    assign in_xfer  = |(IN_VALID & ready_vec);

    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT       <= '0;
            OUT_VALID <= 1'b0;
            OUT_CH    <= '0;
        end else if (in_xfer) begin
            OUT       <= IN_DATA[int'(grant_idx) * n +: n];
            OUT_CH    <= grant_idx;
            OUT_VALID <= 1'b1;
        end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_n_stream.sv
// tb/tb_mux_n_stream.sv - self-checking bench: CH=4 select, CH=4 round-robin, CH=3 select
module tb_mux_n_stream;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [1:0]  sel;
        logic        ordy;
        logic [31:0] word;
        logic [3:0]  e_ready;
        logic        e_ov;
        logic [1:0]  e_ch;
        logic [31:0] e_out;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  valid [3];
    logic [1:0]  sel   [3];
    logic        ordy  [3];
    logic [31:0] data  [3][4];

    logic [127:0] flat0, flat1;
    logic [95:0]  flat3;
    logic [3:0]   rdy0, rdy1;
    logic [2:0]   rdy3;
    logic [31:0]  out0, out1, out3;
    logic         ov0, ov1, ov3;
    logic [1:0]   ch0, ch1, ch3;

    logic [3:0]  a_ready [3];
    logic [31:0] a_out   [3];
    logic        a_ov    [3];
    logic [1:0]  a_ch    [3];

    assign flat0 = {data[0][3], data[0][2], data[0][1], data[0][0]};
    assign flat1 = {data[1][3], data[1][2], data[1][1], data[1][0]};
    assign flat3 = {data[2][2], data[2][1], data[2][0]};

    assign a_ready[0] = rdy0;
    assign a_ready[1] = rdy1;
    assign a_ready[2] = {1'b0, rdy3};
    assign a_out[0] = out0;
    assign a_out[1] = out1;
    assign a_out[2] = out3;
    assign a_ov[0] = ov0;
    assign a_ov[1] = ov1;
    assign a_ov[2] = ov3;
    assign a_ch[0] = ch0;
    assign a_ch[1] = ch1;
    assign a_ch[2] = ch3;

    mux_n_stream #(.n(32), .CH(4), .RR(0)) u_sel4 (
        .CLK(clk), .RST(rst), .IN_DATA(flat0), .IN_VALID(valid[0]), .IN_READY(rdy0),
        .SEL(sel[0]), .OUT(out0), .OUT_VALID(ov0), .OUT_READY(ordy[0]), .OUT_CH(ch0)
    );

    mux_n_stream #(.n(32), .CH(4), .RR(1)) u_rr4 (
        .CLK(clk), .RST(rst), .IN_DATA(flat1), .IN_VALID(valid[1]), .IN_READY(rdy1),
        .SEL(sel[1]), .OUT(out1), .OUT_VALID(ov1), .OUT_READY(ordy[1]), .OUT_CH(ch1)
    );

    mux_n_stream #(.n(32), .CH(3), .RR(0)) u_sel3 (
        .CLK(clk), .RST(rst), .IN_DATA(flat3), .IN_VALID(valid[2][2:0]), .IN_READY(rdy3),
        .SEL(sel[2]), .OUT(out3), .OUT_VALID(ov3), .OUT_READY(ordy[2]), .OUT_CH(ch3)
    );

    int vectors = 0;
    int errors  = 0;

    logic        m_valid [3];
    logic [31:0] m_out   [3];
    logic [1:0]  m_ch    [3];
    int          m_ptr   [3];

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t actual=%h required=%h", name, d, $time, act, exp);
        end
    endtask

    function automatic int nch(input int d);
        return (d == 2) ? 3 : 4;
    endfunction

    // Expected ready vector, straight from the selection rules.
    function automatic logic [3:0] exp_ready(input int d);
        int  c;
        int  i;
        logic load;
        c    = nch(d);
        load = !m_valid[d] || ordy[d];
        if (rst || !load) return 4'b0000;
        if (d == 1) begin
            for (int k = 1; k <= c; k++) begin
                i = (m_ptr[d] + k) % c;
                if (valid[d][i]) return 4'(1) << i;
            end
            return 4'b0000;
        end
        if (int'(sel[d]) < c) return 4'(1) << sel[d];
        return 4'b0000;
    endfunction

    task automatic cycle();
        logic [3:0] er [3];
        int g;
        #1;
        for (int d = 0; d < 3; d++) begin
            er[d] = exp_ready(d);
            chk("in_ready", d, 32'(a_ready[d]), 32'(er[d]));
        end
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                m_valid[d] = 1'b0;
                m_out[d]   = '0;
                m_ch[d]    = '0;
                m_ptr[d]   = nch(d) - 1;
            end else if ((er[d] & valid[d]) != 4'b0000) begin
                g = 0;
                for (int i = 0; i < 4; i++) if (er[d][i]) g = i;
                m_out[d]   = data[d][g];
                m_ch[d]    = 2'(g);
                m_valid[d] = 1'b1;
                if (d == 1) m_ptr[d] = g;
            end else if (ordy[d]) begin
                m_valid[d] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("out_valid", d, 32'(a_ov[d]), 32'(m_valid[d]));
            chk("out_ch", d, 32'(a_ch[d]), 32'(m_ch[d]));
            chk("out", d, a_out[d], m_out[d]);
        end
    endtask

    task automatic set_idle();
        for (int d = 0; d < 3; d++) begin
            valid[d] = 4'b0000;
            sel[d]   = 2'd0;
            ordy[d]  = 1'b1;
            for (int i = 0; i < 4; i++) data[d][i] = '0;
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [1:0] s, input logic o,
                                input logic [31:0] w, input logic [3:0] er, input logic eov,
                                input logic [1:0] ech, input logic [31:0] eout);
        vec_t t;
        t.rst = r; t.valid = v; t.sel = s; t.ordy = o; t.word = w;
        t.e_ready = er; t.e_ov = eov; t.e_ch = ech; t.e_out = eout;
        return t;
    endfunction

    initial begin
        vec_t tbl[$];
        int   fair_a [6];
        int   fair_b [4];

        for (int d = 0; d < 3; d++) begin
            m_valid[d] = 1'b0;
            m_out[d]   = '0;
            m_ch[d]    = '0;
            m_ptr[d]   = nch(d) - 1;
        end
        set_idle();
        rst = 1'b1;

        tbl.push_back(mk(1, 4'hF, 2, 1, 32'h0, 4'h0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 4'hF, 2, 1, 32'h0, 4'h0, 0, 0, 32'h0));
        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk(0, 4'b0100, 2, 1, 32'hA5A5_0000 + k, 4'b0100, 1, 2, 32'hA5A5_0000 + k));
        tbl.push_back(mk(0, 4'b0100, 2, 1, 32'h0000_1234, 4'b0100, 1, 2, 32'h0000_1234));
        tbl.push_back(mk(0, 4'hF, 0, 0, 32'hDEAD_0000, 4'h0, 1, 2, 32'h0000_1234));
        tbl.push_back(mk(0, 4'hF, 3, 0, 32'hDEAD_0001, 4'h0, 1, 2, 32'h0000_1234));
        tbl.push_back(mk(0, 4'hF, 0, 0, 32'hDEAD_0002, 4'h0, 1, 2, 32'h0000_1234));
        tbl.push_back(mk(0, 4'hF, 3, 1, 32'hBEEF_0003, 4'b1000, 1, 3, 32'hBEEF_0003));
        tbl.push_back(mk(0, 4'h0, 0, 1, 32'h0, 4'b0001, 0, 3, 32'hBEEF_0003));
        tbl.push_back(mk(0, 4'h0, 0, 0, 32'h0, 4'b0001, 0, 3, 32'hBEEF_0003));

        foreach (tbl[r]) begin
            set_idle();
            rst      = tbl[r].rst;
            valid[0] = tbl[r].valid;
            sel[0]   = tbl[r].sel;
            ordy[0]  = tbl[r].ordy;
            for (int i = 0; i < 4; i++)
                data[0][i] = (i == int'(tbl[r].sel)) ? tbl[r].word
                                                     : (tbl[r].word ^ {16'hFFFF, 14'h0, 2'(i)});
            #1;
            chk("tbl_ready", 0, 32'(rdy0), 32'(tbl[r].e_ready));
            cycle();
            chk("tbl_out_valid", 0, 32'(ov0), 32'(tbl[r].e_ov));
            chk("tbl_out_ch", 0, 32'(ch0), 32'(tbl[r].e_ch));
            chk("tbl_out", 0, out0, tbl[r].e_out);
        end

        // Round-robin fairness from reset: all valid, then alternate channels.
        fair_a = '{0, 1, 2, 3, 0, 1};
        fair_b = '{1, 3, 1, 3};
        set_idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        valid[1] = 4'hF;
        for (int i = 0; i < 4; i++) data[1][i] = 32'h1000_0000 + i;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_fair_ready", 1, 32'(rdy1), 32'(4'(1) << fair_a[k]));
            cycle();
            chk("rr_fair_ch", 1, 32'(ch1), 32'(fair_a[k]));
            chk("rr_fair_out", 1, out1, 32'h1000_0000 + fair_a[k]);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        valid[1] = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("rr_alt_ch", 1, 32'(ch1), 32'(fair_b[k]));
        end

        // Backpressure after a ch1 grant must not re-grant ch1.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        valid[1] = 4'b0010;
        cycle();
        chk("rr_bp_first", 1, 32'(ch1), 32'd1);
        valid[1] = 4'hF;
        ordy[1]  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_bp_ready", 1, 32'(rdy1), 32'd0);
            cycle();
            chk("rr_bp_hold_ch", 1, 32'(ch1), 32'd1);
            chk("rr_bp_hold_ov", 1, 32'(ov1), 32'd1);
            chk("rr_bp_hold_out", 1, out1, 32'h1000_0001);
        end
        ordy[1] = 1'b1;
        #1;
        chk("rr_bp_release_ready", 1, 32'(rdy1), 32'b0100);
        cycle();
        chk("rr_bp_next_ch", 1, 32'(ch1), 32'd2);

        // CH=3: out-of-range select grants nobody, then a legal one loads.
        set_idle();
        valid[2] = 4'b0111;
        sel[2]   = 2'd3;
        for (int i = 0; i < 4; i++) data[2][i] = 32'h3000_0000 + i;
        #1;
        chk("ch3_sel3_ready", 2, 32'(rdy3), 32'd0);
        cycle();
        chk("ch3_sel3_ov", 2, 32'(ov3), 32'd0);
        sel[2] = 2'd2;
        #1;
        chk("ch3_sel2_ready", 2, 32'(rdy3), 32'b100);
        cycle();
        chk("ch3_sel2_ov", 2, 32'(ov3), 32'd1);
        chk("ch3_sel2_out", 2, out3, 32'h3000_0002);
        chk("ch3_sel2_ch", 2, 32'(ch3), 32'd2);

        // Randomised traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            for (int d = 0; d < 3; d++) begin
                valid[d] = 4'($urandom_range(0, 15));
                if (d == 2) valid[d][3] = 1'b0;
                sel[d]   = 2'($urandom_range(0, 3));
                ordy[d]  = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < 4; i++) data[d][i] = $urandom;
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
